inst_sequencer: RTL and testbench
=================================

// Module: inst_sequencer
// PURPOSE
//  Instruction-cycle sequencer and fetch/branch control for the 4-bit CPU; sits directly upstream of the PC stack.
//  - Generates the 8-phase cycle count: 0-2 PC out, 3-4 instruction nibbles in, 5-7 execute.
//  - Captures opcode/operand from the data bus and tracks two-word instructions.
//  - Drives the PC stack's pc_write_enable/pc_next_sel for JUN, JCN and JIN.
// PARAMETERS
//  OP_JCN   4'h1  opcode of conditional jump (two-word)
//  OP_JIN   4'h3  opcode of indirect jump (one-word, operand[0]=1)
//  OP_JUN   4'h4  opcode of unconditional jump (two-word)
// PORTS
//  clock            in   1  system clock
//  reset            in   1  synchronous, active-high
//  halt_req         in   1  request to stop at next instruction boundary
//  data             in   4  data bus nibble
//  acc_zero         in   1  accumulator == 0 (JCN condition)
//  carry_flag       in   1  ALU carry (JCN condition)
//  test_n           in   1  TEST pin, active-low (JCN condition)
//  cycle            out  3  current phase 0..7
//  halt             out  1  CPU halted; PC stack freezes
//  inst_opcode      out  4  word-1 OPR nibble
//  inst_operand     out  4  word-1 OPA nibble
//  second_word      out  1  current fetch is the 2nd word of JUN/JCN
//  reg_pair_addr    out  4  register-file index for JIN reads
//  pc_next_sel      out  2  PC_FROM_DATA / PC_FROM_REG
//  pc_write_enable  out  2  [0]=load PC[3:0], [1]=load PC[7:4]; never both set
// BEHAVIOUR
//  Reset: cycle=0, halt=0, opcode=operand=0 (NOP), state=WORD1, second_word=0.
//  - pc_write_enable=0, reg_pair_addr=0.
//  - Reset mid-instruction abandons it: no PC write in the following cycle.
//  Cycle counter: +1 per clock, wraps 7->0; holds its value while halt=1.
//  Halt:
//  - halt_req sampled only when cycle==7; halt sets on that edge, so cycle holds at 0.
//  - halt clears on the edge after halt_req deasserts; counting resumes from 0.
//  - halt_req outside cycle 7 has no effect until the next cycle 7.
//  WORD1 capture: opcode <= data at cycle 3; operand <= data at cycle 4.
//  - Both are registered and valid from the next cycle.
//  - In WORD2/SKIP states opcode/operand are NOT overwritten.
//  State machine (transitions only on the cycle-7 edge, not halted):
//  - WORD1 -> WORD2 if opcode==OP_JUN.
//  - WORD1 -> WORD2 if opcode==OP_JCN and cond=1.
//  - WORD1 -> SKIP  if opcode==OP_JCN and cond=0.
//  - WORD1 -> WORD1 otherwise; WORD2 -> WORD1; SKIP -> WORD1.
//  - cond = operand[3] ^ ((operand[2]&acc_zero) | (operand[1]&carry_flag) | (operand[0]&~test_n)).
//  - Flags are sampled at that same cycle-7 edge.
//  second_word = (state==WORD2 || state==SKIP).
//  PC control (combinational from state, cycle, opcode, operand); otherwise enable=0, sel=PC_FROM_DATA:
//  - WORD2, cycle 3: enable=2'b10, sel=PC_FROM_DATA (OPR -> PC[7:4]).
//  - WORD2, cycle 4: enable=2'b01, sel=PC_FROM_DATA (OPA -> PC[3:0]).
//  - WORD1, opcode==OP_JIN, operand[0]=1, cycle 6: enable=2'b10, sel=PC_FROM_REG, reg_pair_addr={operand[3:1],1'b0}.
//  - WORD1, opcode==OP_JIN, operand[0]=1, cycle 7: enable=2'b01, sel=PC_FROM_REG, reg_pair_addr={operand[3:1],1'b1}.
//  - SKIP: no writes; the 2nd word is fetched and discarded (PC already advanced).
//  - All PC-control outputs are forced to 0 while halt=1 or reset=1.
//  - Never write in cycles 0-2 (the PC stack increments there).
//  JUN's word-1 operand (A3) is ignored: the PC is 8-bit.
// STRUCTURE
//  Shared header (with the PC stack): PC_FROM_DATA=2'd0, PC_FROM_REG=2'd1, opcode constants, state encoding.
//  - State encoding: WORD1=2'd0, WORD2=2'd1, SKIP=2'd2.
//  One sub-module: jcn_cond_eval (combinational condition; 4-bit operand + 3 flags -> cond).
//  Counter, instruction register and FSM stay in this module.
// TESTING
//  1. Reset released, data=0 -> cycle runs 0..7,0.
//     - opcode=0; pc_write_enable=0 throughout; second_word=0.
//  2. JUN: word1 data 4,0; word2 data 9,6.
//     - Word2 cycle 3: enable=10, sel=DATA.
//     - Word2 cycle 4: enable=01.
//     - Next WORD1 fetch shows PC 0x96.
//  3. JCN operand 4'b0100, acc_zero=1 -> WORD2 with writes.
//     - Same with acc_zero=0 -> SKIP: no writes, second_word=1, then WORD1.
//  4. JIN: data 3,5 (pair 2).
//     - cycle 6: enable=10, sel=REG, reg_pair_addr=4.
//     - cycle 7: enable=01, reg_pair_addr=5.
//  5. halt_req pulsed at cycle 2 -> no halt.
//     - halt_req held through cycle 7 -> halt=1, cycle frozen at 0.
//     - Release -> resumes at 0 with no lost write.
//  6. Reset asserted in WORD2 cycle 3 -> next cycle: cycle=0, state WORD1, enable=0, opcode=0.

Source files
------------

// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the PC stack it drives.
// Holds the opcode constants, the PC source selects and the sequencer state encoding.
package inst_sequencer_pkg;

  localparam logic [3:0] OPC_JCN = 4'h1;
  localparam logic [3:0] OPC_JIN = 4'h3;
  localparam logic [3:0] OPC_JUN = 4'h4;

  localparam logic [1:0] PC_FROM_DATA = 2'd0;
  localparam logic [1:0] PC_FROM_REG  = 2'd1;

  localparam logic [2:0] CYC_NIB_HI = 3'd3;
  localparam logic [2:0] CYC_NIB_LO = 3'd4;
  localparam logic [2:0] CYC_REG_HI = 3'd6;
  localparam logic [2:0] CYC_LAST   = 3'd7;

  typedef enum logic [1:0] {
    WORD1 = 2'd0,
    WORD2 = 2'd1,
    SKIP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/inst_sequencer_jcn_cond_eval.sv
// Conditional-jump test: operand[3] inverts, operand[2:0] select acc_zero, carry and TEST.
// TEST is an active-low pin, so its condition is true when the pin is low.
module jcn_cond_eval (
  input  logic [3:0] operand,
  input  logic       acc_zero,
  input  logic       carry_flag,
  input  logic       test_n,
  output logic       cond
);

  logic any_hit;

  assign any_hit = (operand[2] & acc_zero) |
                   (operand[1] & carry_flag) |
                   (operand[0] & ~test_n);
  assign cond    = operand[3] ^ any_hit;

endmodule

// File: rtl/inst_sequencer.sv
// 8-phase instruction-cycle sequencer with instruction capture and JUN/JCN/JIN PC control.
// Phases 0-2 belong to the PC stack's increment, so no PC write is ever issued there.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter logic [3:0] OP_JCN = OPC_JCN,
  parameter logic [3:0] OP_JIN = OPC_JIN,
  parameter logic [3:0] OP_JUN = OPC_JUN
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       halt_req,
  input  logic [3:0] data,
  input  logic       acc_zero,
  input  logic       carry_flag,
  input  logic       test_n,
  output logic [2:0] cycle,
  output logic       halt,
  output logic [3:0] inst_opcode,
  output logic [3:0] inst_operand,
  output logic       second_word,
  output logic [3:0] reg_pair_addr,
  output logic [1:0] pc_next_sel,
  output logic [1:0] pc_write_enable,
  output logic [1:0] state_dbg
);

  logic [2:0] cycle_q;
  logic       halt_q;
  logic [3:0] opcode_q;
  logic [3:0] operand_q;
  seq_state_t state_q;
  seq_state_t state_d;
  logic       cond;
  logic       boundary;
  logic       is_jin;

  logic [1:0] pc_we_c;
  logic [1:0] pc_sel_c;
  logic [3:0] rpa_c;

  jcn_cond_eval u_cond (
    .operand    (operand_q),
    .acc_zero   (acc_zero),
    .carry_flag (carry_flag),
    .test_n     (test_n),
    .cond       (cond)
  );

  // Instruction boundary: the only edge where state and halt may change.
  assign boundary = (cycle_q == CYC_LAST) && !halt_q;
  assign is_jin   = (opcode_q == OP_JIN) && operand_q[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q <= 3'd0;
    end else if (!halt_q) begin
      cycle_q <= cycle_q + 3'd1;
    end
  end

  // Once halted, halt simply follows the request so release happens on the next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      halt_q <= 1'b0;
    end else if (halt_q) begin
      halt_q <= halt_req;
    end else if (cycle_q == CYC_LAST) begin
      halt_q <= halt_req;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opcode_q  <= 4'h0;
      operand_q <= 4'h0;
    end else if ((state_q == WORD1) && !halt_q) begin
      if (cycle_q == CYC_NIB_HI) opcode_q  <= data;
      if (cycle_q == CYC_NIB_LO) operand_q <= data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WORD1;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (boundary) begin
      case (state_q)
        WORD1: begin
          if (opcode_q == OP_JUN) begin
            state_d = WORD2;
          end else if (opcode_q == OP_JCN) begin
            state_d = cond ? WORD2 : SKIP;
          end else begin
            state_d = WORD1;
          end
        end
        WORD2:   state_d = WORD1;
        SKIP:    state_d = WORD1;
        default: state_d = WORD1;
      endcase
    end
  end

  // SKIP fetches the second word without writing; the PC has already moved past it.
  always_comb begin
    pc_we_c  = 2'b00;
    pc_sel_c = PC_FROM_DATA;
    rpa_c    = 4'h0;
    if (!reset && !halt_q) begin
      case (state_q)
        WORD2: begin
          if (cycle_q == CYC_NIB_HI) begin
            pc_we_c = 2'b10;
          end else if (cycle_q == CYC_NIB_LO) begin
            pc_we_c = 2'b01;
          end
        end
        WORD1: begin
          if (is_jin && (cycle_q == CYC_REG_HI)) begin
            pc_we_c  = 2'b10;
            pc_sel_c = PC_FROM_REG;
            rpa_c    = {operand_q[3:1], 1'b0};
          end else if (is_jin && (cycle_q == CYC_LAST)) begin
            pc_we_c  = 2'b01;
            pc_sel_c = PC_FROM_REG;
            rpa_c    = {operand_q[3:1], 1'b1};
          end
        end
        default: begin
          pc_we_c  = 2'b00;
          pc_sel_c = PC_FROM_DATA;
          rpa_c    = 4'h0;
        end
      endcase
    end
  end

  assign cycle           = cycle_q;
  assign halt            = halt_q;
  assign inst_opcode     = opcode_q;
  assign inst_operand    = operand_q;
  assign second_word     = (state_q == WORD2) || (state_q == SKIP);
  assign reg_pair_addr   = rpa_c;
  assign pc_next_sel     = pc_sel_c;
  assign pc_write_enable = pc_we_c;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: per-instruction vector table expanded over 8 phases,
// plus hand-written halt and mid-instruction reset sequences.
module tb_inst_sequencer;

  logic       clock;
  logic       reset;
  logic       halt_req;
  logic [3:0] data;
  logic       acc_zero;
  logic       carry_flag;
  logic       test_n;
  logic [2:0] cycle;
  logic       halt;
  logic [3:0] inst_opcode;
  logic [3:0] inst_operand;
  logic       second_word;
  logic [3:0] reg_pair_addr;
  logic [1:0] pc_next_sel;
  logic [1:0] pc_write_enable;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  logic [7:0] pc_model;

  typedef struct {
    logic [3:0]  d_hi;
    logic [3:0]  d_lo;
    logic        az;
    logic        cf;
    logic        tn;
    logic [7:0]  hreq;
    logic [1:0]  st;
    logic [3:0]  opc;
    logic [3:0]  opa;
    logic [15:0] we;
    logic [15:0] sel;
    logic [3:0]  rpa6;
    logic [3:0]  rpa7;
    logic [7:0]  pc;
  } vec_t;

  vec_t tab[18];

  inst_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .halt_req        (halt_req),
    .data            (data),
    .acc_zero        (acc_zero),
    .carry_flag      (carry_flag),
    .test_n          (test_n),
    .cycle           (cycle),
    .halt            (halt),
    .inst_opcode     (inst_opcode),
    .inst_operand    (inst_operand),
    .second_word     (second_word),
    .reg_pair_addr   (reg_pair_addr),
    .pc_next_sel     (pc_next_sel),
    .pc_write_enable (pc_write_enable),
    .state_dbg       (state_dbg)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] rf_val(input logic [3:0] a);
    return a ^ 4'hC;
  endfunction

  // Stand-in for the PC stack: loads nibbles from the bus or the register file.
  always @(posedge clock) begin
    if (pc_write_enable[1])
      pc_model[7:4] <= (pc_next_sel == 2'd1) ? rf_val(reg_pair_addr) : data;
    if (pc_write_enable[0])
      pc_model[3:0] <= (pc_next_sel == 2'd1) ? rf_val(reg_pair_addr) : data;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic run_instr(input int k);
    vec_t v;
    logic [3:0] exp_rpa;
    v = tab[k];
    for (int c = 0; c < 8; c++) begin
      halt_req   = v.hreq[c];
      acc_zero   = v.az;
      carry_flag = v.cf;
      test_n     = v.tn;
      if (c == 3)      data = v.d_hi;
      else if (c == 4) data = v.d_lo;
      else             data = 4'($urandom_range(0, 15));
      #1;
      exp_rpa = (c == 6) ? v.rpa6 : (c == 7) ? v.rpa7 : 4'h0;
      chk($sformatf("i%0d c%0d cycle", k, c), cycle, c);
      chk($sformatf("i%0d c%0d halt", k, c), halt, 0);
      chk($sformatf("i%0d c%0d state", k, c), state_dbg, v.st);
      chk($sformatf("i%0d c%0d second_word", k, c), second_word, (v.st != 2'd0));
      chk($sformatf("i%0d c%0d we", k, c), pc_write_enable, v.we[2*c +: 2]);
      chk($sformatf("i%0d c%0d sel", k, c), pc_next_sel, v.sel[2*c +: 2]);
      chk($sformatf("i%0d c%0d rpa", k, c), reg_pair_addr, exp_rpa);
      if (c >= 5) begin
        chk($sformatf("i%0d c%0d opcode", k, c), inst_opcode, v.opc);
        chk($sformatf("i%0d c%0d operand", k, c), inst_operand, v.opa);
      end
      @(posedge clock);
      #1;
    end
    chk($sformatf("i%0d pc", k), pc_model, v.pc);
  endtask

  initial begin
    //            hi    lo    az    cf    tn    hreq   st    opc   opa   we       sel      rpa6  rpa7  pc
    tab[0]  = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 8'h00};
    tab[1]  = '{4'h4, 4'h0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 4'h4, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 8'h00};
    tab[2]  = '{4'h9, 4'h6, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 4'h4, 4'h0, 16'h0180, 16'h0000, 4'h0, 4'h0, 8'h96};
    tab[3]  = '{4'h1, 4'h4, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0, 4'h1, 4'h4, 16'h0000, 16'h0000, 4'h0, 4'h0, 8'h96};
    tab[4]  = '{4'h2, 4'h3, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 4'h1, 4'h4, 16'h0180, 16'h0000, 4'h0, 4'h0, 8'h23};
    tab[5]  = '{4'h1, 4'h4, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 4'h1, 4'h4, 16'h0000, 16'h0000, 4'h0, 4'h0, 8'h23};
    tab[6]  = '{4'h7, 4'h7, 1'b0, 1'b0, 1'b1, 8'h00, 2'd2, 4'h1, 4'h4, 16'h0000, 16'h0000, 4'h0, 4'h0, 8'h23};
    tab[7]  = '{4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 4'h1, 4'h1, 16'h0000, 16'h0000, 4'h0, 4'h0, 8'h23};
    tab[8]  = '{4'hA, 4'h5, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 4'h1, 4'h1, 16'h0180, 16'h0000, 4'h0, 4'h0, 8'hA5};
    tab[9]  = '{4'h1, 4'hA, 1'b0, 1'b1, 1'b1, 8'h00, 2'd0, 4'h1, 4'hA, 16'h0000, 16'h0000, 4'h0, 4'h0, 8'hA5};
    tab[10] = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd2, 4'h1, 4'hA, 16'h0000, 16'h0000, 4'h0, 4'h0, 8'hA5};
    tab[11] = '{4'h3, 4'h5, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 4'h3, 4'h5, 16'h6000, 16'h5000, 4'h4, 4'h5, 8'h89};
    tab[12] = '{4'h3, 4'h4, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 4'h3, 4'h4, 16'h0000, 16'h0000, 4'h0, 4'h0, 8'h89};
    tab[13] = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 8'h89};
    tab[14] = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 8'h04, 2'd0, 4'h0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 8'h89};
    tab[15] = '{4'h4, 4'h0, 1'b0, 1'b0, 1'b1, 8'hC0, 2'd0, 4'h4, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 8'h89};
    tab[16] = '{4'h5, 4'hC, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 4'h4, 4'h0, 16'h0180, 16'h0000, 4'h0, 4'h0, 8'h5C};
    tab[17] = '{4'h4, 4'h0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 4'h4, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 8'h5C};

    pc_model   = 8'h00;
    reset      = 1'b1;
    halt_req   = 1'b0;
    data       = 4'h0;
    acc_zero   = 1'b0;
    carry_flag = 1'b0;
    test_n     = 1'b1;
    step;
    step;
    chk("rst cycle", cycle, 0);
    chk("rst halt", halt, 0);
    chk("rst opcode", inst_opcode, 0);
    chk("rst operand", inst_operand, 0);
    chk("rst second_word", second_word, 0);
    chk("rst state", state_dbg, 0);
    chk("rst we", pc_write_enable, 0);
    chk("rst rpa", reg_pair_addr, 0);
    reset = 1'b0;

    for (int k = 0; k <= 15; k++) run_instr(k);

    // Halt entered at the JUN word-1 boundary; the pending word 2 must survive it.
    for (int i = 0; i < 4; i++) begin
      halt_req = 1'b1;
      data     = 4'($urandom_range(0, 15));
      #1;
      chk($sformatf("halted%0d halt", i), halt, 1);
      chk($sformatf("halted%0d cycle", i), cycle, 0);
      chk($sformatf("halted%0d state", i), state_dbg, 1);
      chk($sformatf("halted%0d we", i), pc_write_enable, 0);
      @(posedge clock);
      #1;
    end
    halt_req = 1'b0;
    #1;
    chk("release pre halt", halt, 1);
    step;
    chk("release halt", halt, 0);
    chk("release cycle", cycle, 0);
    chk("release pc", pc_model, 8'h89);
    run_instr(16);

    // Reset landing in WORD2 phase 3 must abandon the jump.
    run_instr(17);
    for (int c = 0; c < 3; c++) begin
      data = 4'($urandom_range(0, 15));
      step;
    end
    chk("pre-reset cycle", cycle, 3);
    chk("pre-reset state", state_dbg, 1);
    data  = 4'hE;
    reset = 1'b1;
    #1;
    chk("in-reset we", pc_write_enable, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("post-reset cycle", cycle, 0);
    chk("post-reset state", state_dbg, 0);
    chk("post-reset second_word", second_word, 0);
    chk("post-reset we", pc_write_enable, 0);
    chk("post-reset opcode", inst_opcode, 0);
    chk("post-reset operand", inst_operand, 0);
    chk("post-reset halt", halt, 0);
    @(posedge clock);
    #1;
    chk("post-reset cycle+1", cycle, 1);
    chk("post-reset we+1", pc_write_enable, 0);
    chk("post-reset pc", pc_model, 8'h5C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
